operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/riscv_pkg.sv | 12 +
 rtl/operand_bypass.sv | 22 ++
 rtl/operand_fetch.sv | 105 ++++++++++
 tb/tb_operand_fetch.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 register-file geometry and instruction field positions.
package riscv_pkg;

  localparam int REGISTER_COUNT       = 32;
  localparam int REGISTER_INDEX_WIDTH = $clog2(REGISTER_COUNT);
  localparam logic [REGISTER_INDEX_WIDTH-1:0] X0 = '0;

  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;

endpackage

// File: rtl/operand_bypass.sv
// Single-operand source select: x0 forced to zero, else writeback snoop, else regfile.
module operand_bypass
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [REGISTER_INDEX_WIDTH-1:0] i_idx,
  input  logic [XLEN-1:0]                 i_rf_data,
  input  logic                            i_wb_wen,
  input  logic [REGISTER_INDEX_WIDTH-1:0] i_wb_addr,
  input  logic [XLEN-1:0]                 i_wb_wdata,
  output logic [XLEN-1:0]                 o_operand
);

  logic w_hit;

  // The regfile has no write-through, so a same-cycle write must be forwarded here.
  assign w_hit     = i_wb_wen && (i_wb_addr == i_idx);
  assign o_operand = (i_idx == X0) ? '0 :
                     w_hit         ? i_wb_wdata : i_rf_data;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: regfile read with writeback bypass into a single-entry
// skid-free pipeline register whose held operands track later writebacks.
module operand_fetch
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [31:0]                     in_instr,
  input  logic [XLEN-1:0]                 in_pc,
  output logic [REGISTER_INDEX_WIDTH-1:0] rs1_addr,
  output logic [REGISTER_INDEX_WIDTH-1:0] rs2_addr,
  input  logic [XLEN-1:0]                 rs1_data,
  input  logic [XLEN-1:0]                 rs2_data,
  input  logic                            wb_wen,
  input  logic [REGISTER_INDEX_WIDTH-1:0] wb_addr,
  input  logic [XLEN-1:0]                 wb_wdata,
  input  logic                            flush,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [XLEN-1:0]                 out_pc,
  output logic [31:0]                     out_instr,
  output logic [REGISTER_INDEX_WIDTH-1:0] out_rd,
  output logic [XLEN-1:0]                 out_rs1_val,
  output logic [XLEN-1:0]                 out_rs2_val
);

  logic                            r_valid;
  logic [XLEN-1:0]                 r_pc;
  logic [31:0]                     r_instr;
  logic [XLEN-1:0]                 r_rs1_val;
  logic [XLEN-1:0]                 r_rs2_val;

  logic [XLEN-1:0]                 w_rs1_op;
  logic [XLEN-1:0]                 w_rs2_op;
  logic [REGISTER_INDEX_WIDTH-1:0] w_held_rs1;
  logic [REGISTER_INDEX_WIDTH-1:0] w_held_rs2;
  logic                            w_accept;
  logic                            w_held_upd1;
  logic                            w_held_upd2;

  assign rs1_addr = in_instr[RS1_LSB +: REGISTER_INDEX_WIDTH];
  assign rs2_addr = in_instr[RS2_LSB +: REGISTER_INDEX_WIDTH];

  operand_bypass #(.XLEN(XLEN)) u_bypass_rs1 (
    .i_idx      (rs1_addr),
    .i_rf_data  (rs1_data),
    .i_wb_wen   (wb_wen),
    .i_wb_addr  (wb_addr),
    .i_wb_wdata (wb_wdata),
    .o_operand  (w_rs1_op)
  );

  operand_bypass #(.XLEN(XLEN)) u_bypass_rs2 (
    .i_idx      (rs2_addr),
    .i_rf_data  (rs2_data),
    .i_wb_wen   (wb_wen),
    .i_wb_addr  (wb_addr),
    .i_wb_wdata (wb_wdata),
    .o_operand  (w_rs2_op)
  );

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready && !flush;

  // Held operands are refreshed by writes to their source index so they never go stale.
  assign w_held_rs1  = r_instr[RS1_LSB +: REGISTER_INDEX_WIDTH];
  assign w_held_rs2  = r_instr[RS2_LSB +: REGISTER_INDEX_WIDTH];
  assign w_held_upd1 = wb_wen && (wb_addr != X0) && (wb_addr == w_held_rs1);
  assign w_held_upd2 = wb_wen && (wb_addr != X0) && (wb_addr == w_held_rs2);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_instr   <= '0;
      r_rs1_val <= '0;
      r_rs2_val <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_pc      <= in_pc;
      r_instr   <= in_instr;
      r_rs1_val <= w_rs1_op;
      r_rs2_val <= w_rs2_op;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end else if (r_valid) begin
      if (w_held_upd1) r_rs1_val <= wb_wdata;
      if (w_held_upd2) r_rs2_val <= wb_wdata;
    end
  end

  assign out_valid   = r_valid;
  assign out_pc      = r_pc;
  assign out_instr   = r_instr;
  assign out_rd      = r_instr[RD_LSB +: REGISTER_INDEX_WIDTH];
  assign out_rs1_val = r_rs1_val;
  assign out_rs2_val = r_rs2_val;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table, stall/flush/reset sequences,
// and a randomized run checked against an architectural-register reference model.
module tb_operand_fetch;

  logic        clk;
  logic        n_rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_wen;
  logic [4:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [4:0]  out_rd;
  logic [31:0] out_rs1_val;
  logic [31:0] out_rs2_val;

  logic [31:0] rf [32];

  int n_vec;
  int n_err;

  operand_fetch #(.XLEN(32)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .wb_wen      (wb_wen),
    .wb_addr     (wb_addr),
    .wb_wdata    (wb_wdata),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_rd      (out_rd),
    .out_rs1_val (out_rs1_val),
    .out_rs2_val (out_rs2_val)
  );

  // Regfile model: combinational read, write committed at the clock edge, x0 never written.
  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] v1;
    logic [31:0] v2;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [31:0] mk_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [4:0] rd);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] arch(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : rf[idx];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (wb_wen && wb_addr != 5'd0) rf[wb_addr] = wb_wdata;
  endtask

  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] ins;

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : 32'h01010101 * i;

    vecs[0] = '{rs1:5'd1,  rs2:5'd2,  rd:5'd3,  v1:32'h12345678, v2:32'hdeadbeef, wen:1'b0,
                waddr:5'd0,  wdata:32'h0,        e1:32'h12345678, e2:32'hdeadbeef};
    vecs[1] = '{rs1:5'd5,  rs2:5'd6,  rd:5'd1,  v1:32'haaaa0001, v2:32'h00000606, wen:1'b1,
                waddr:5'd5,  wdata:32'hbbbb0002, e1:32'hbbbb0002, e2:32'h00000606};
    vecs[2] = '{rs1:5'd0,  rs2:5'd4,  rd:5'd2,  v1:32'h00000055, v2:32'h00000044, wen:1'b1,
                waddr:5'd0,  wdata:32'hffffffff, e1:32'h00000000, e2:32'h00000044};
    vecs[3] = '{rs1:5'd9,  rs2:5'd9,  rd:5'd9,  v1:32'h00000099, v2:32'h00000099, wen:1'b1,
                waddr:5'd9,  wdata:32'h0badf00d, e1:32'h0badf00d, e2:32'h0badf00d};
    vecs[4] = '{rs1:5'd3,  rs2:5'd10, rd:5'd31, v1:32'h00000033, v2:32'h00001010, wen:1'b1,
                waddr:5'd10, wdata:32'h00000077, e1:32'h00000033, e2:32'h00000077};
    vecs[5] = '{rs1:5'd11, rs2:5'd12, rd:5'd0,  v1:32'h11111111, v2:32'h12121212, wen:1'b1,
                waddr:5'd13, wdata:32'h00000013, e1:32'h11111111, e2:32'h12121212};

    n_rst = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; wb_wen = 1'b0;
    wb_addr = '0; wb_wdata = '0; flush = 1'b0; out_ready = 1'b0;

    // Reset state, observed before any clock edge.
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_rs1", out_rs1_val, 32'd0);
    #10 n_rst = 1'b1;
    tick();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed single-accept vectors.
    for (int i = 0; i < 6; i++) begin
      rf[vecs[i].rs1] = vecs[i].v1;
      rf[vecs[i].rs2] = vecs[i].v2;
      in_valid  = 1'b1;
      in_instr  = mk_instr(vecs[i].rs1, vecs[i].rs2, vecs[i].rd);
      in_pc     = 32'h1000 + 32'(i * 4);
      wb_wen    = vecs[i].wen;
      wb_addr   = vecs[i].waddr;
      wb_wdata  = vecs[i].wdata;
      out_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_rs1_addr", i), {27'd0, rs1_addr}, {27'd0, vecs[i].rs1});
      chk($sformatf("v%0d_rs2_addr", i), {27'd0, rs2_addr}, {27'd0, vecs[i].rs2});
      tick();
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_rs1_val", i), out_rs1_val, vecs[i].e1);
      chk($sformatf("v%0d_rs2_val", i), out_rs2_val, vecs[i].e2);
      chk($sformatf("v%0d_rd", i), {27'd0, out_rd}, {27'd0, vecs[i].rd});
      chk($sformatf("v%0d_pc", i), out_pc, 32'h1000 + 32'(i * 4));
      in_valid = 1'b0;
      wb_wen   = 1'b0;
      tick();
      chk($sformatf("v%0d_drain", i), {31'd0, out_valid}, 32'd0);
    end
    rf[0] = 32'd0;

    // Stall with a writeback to a held source index.
    rf[3] = 32'h00000300;
    rf[7] = 32'h00000700;
    in_valid = 1'b1; in_instr = mk_instr(5'd3, 5'd7, 5'd4); in_pc = 32'h100; out_ready = 1'b0;
    tick();
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_rs2_init", out_rs2_val, 32'h00000700);
    chk("stall_in_ready0", {31'd0, in_ready}, 32'd0);
    in_instr = mk_instr(5'd1, 5'd2, 5'd5); in_pc = 32'h200;
    wb_wen = 1'b1; wb_addr = 5'd7; wb_wdata = 32'h0000cafe;
    #1;
    chk("stall_in_ready1", {31'd0, in_ready}, 32'd0);
    tick();
    chk("stall_rs2_upd", out_rs2_val, 32'h0000cafe);
    chk("stall_rs1_keep", out_rs1_val, 32'h00000300);
    chk("stall_pc_keep", out_pc, 32'h100);
    chk("stall_instr_keep", out_instr, mk_instr(5'd3, 5'd7, 5'd4));
    chk("stall_in_ready2", {31'd0, in_ready}, 32'd0);
    wb_wen = 1'b0;
    tick();
    chk("stall_pc_keep2", out_pc, 32'h100);

    // Flush overrides a held bundle and an incoming instruction.
    flush = 1'b1;
    tick();
    chk("flush_held_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("flush_empty_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0;

    // Back-to-back flow without bubbles.
    for (int k = 0; k < 3; k++) begin
      in_pc = 32'(k * 4);
      tick();
      chk($sformatf("b2b%0d_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("b2b%0d_pc", k), out_pc, 32'(k * 4));
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_drain", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset in the middle of a stall.
    in_valid = 1'b1; in_pc = 32'h300; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rstmid_held", {31'd0, out_valid}, 32'd1);
    #3 n_rst = 1'b0;
    #1;
    chk("rstmid_valid", {31'd0, out_valid}, 32'd0);
    chk("rstmid_pc", out_pc, 32'd0);
    chk("rstmid_rs1", out_rs1_val, 32'd0);
    chk("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
    #2 n_rst = 1'b1;
    tick();
    chk("rstmid_after", {31'd0, out_valid}, 32'd0);

    // Randomized run: any valid bundle's operands equal the architectural register values.
    m_valid = 1'b0; m_pc = '0; m_instr = '0;
    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      in_instr  = ins;
      in_pc     = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 15) == 0);
      wb_wen    = ($urandom_range(0, 1) == 1);
      wb_addr   = 5'($urandom_range(0, 7));
      wb_wdata  = $urandom;
      #1;
      chk("rnd_in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
      chk("rnd_rs1_addr", {27'd0, rs1_addr}, {27'd0, ins[19:15]});
      if (flush)                               m_valid = 1'b0;
      else if (in_valid && (!m_valid || out_ready)) begin
        m_valid = 1'b1; m_pc = in_pc; m_instr = ins;
      end else if (out_ready)                  m_valid = 1'b0;
      tick();
      chk("rnd_valid", {31'd0, out_valid}, {31'd0, m_valid});
      if (m_valid) begin
        chk("rnd_pc", out_pc, m_pc);
        chk("rnd_instr", out_instr, m_instr);
        chk("rnd_rd", {27'd0, out_rd}, {27'd0, m_instr[11:7]});
        chk("rnd_rs1_val", out_rs1_val, arch(m_instr[19:15]));
        chk("rnd_rs2_val", out_rs2_val, arch(m_instr[24:20]));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
